mem_wb_datapath: RTL and testbench

- MIPS pipeline memory-access core: byte-addressed data RAM with word stores and word/halfword/byte loads, followed by the MEM/WB pipeline register.
- Sits between the EX/MEM register and the write-back mux.
- Branch resolution (pc_src) stays outside this block.

---
 rtl/mem_wb_datapath.sv | 128 ++++++++++++
 tb/tb_mem_wb_datapath.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_datapath.sv
// ============================================================================
// mem_wb_datapath : big-endian data RAM (word store, LW/LH/LHU/LB) + MEM/WB reg
// Optional macro MEM_MISALIGN_CHECK_EN adds mem_misaligned.  Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_datapath #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_LSBS = $clog2(MEM_BYTES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic [4:0]  write_back_destination,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        mem_misaligned,
`endif
    output logic [31:0] read_memory_out,
    output logic [4:0]  write_back_destination_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [31:0] read_data,
    output logic [31:0] address_out
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = (ADDR_LSBS > 2) ? ADDR_LSBS - 2 : 1;

    localparam logic [1:0] LM_LW  = 2'b00;
    localparam logic [1:0] LM_LH  = 2'b01;
    localparam logic [1:0] LM_LHU = 2'b10;
    localparam logic [1:0] LM_LB  = 2'b11;

    // Word-organised storage; byte 0 of a word sits in bits [31:24].
    logic [31:0]      r_mem [WORDS];
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic [15:0]      w_half;
    logic [7:0]       w_byte;
    logic [31:0]      w_load;
    logic             w_load_bad;
    logic             w_store_bad;
    logic             w_store_en;
    logic             w_unused_addr;

    generate
        if (WORDS > 1) begin : g_idx_multi
            assign w_idx = address[ADDR_LSBS-1:2];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    assign w_unused_addr = ^address[31:ADDR_LSBS];

    assign w_word = r_mem[w_idx];
    assign w_half = address[1] ? w_word[15:0] : w_word[31:16];

    always_comb begin
        w_byte = w_word[31:24];
        case (address[1:0])
            2'd0:    w_byte = w_word[31:24];
            2'd1:    w_byte = w_word[23:16];
            2'd2:    w_byte = w_word[15:8];
            default: w_byte = w_word[7:0];
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_load_bad  = mem_read &&
                         (((load_mode == LM_LW) && (address[1:0] != 2'b00)) ||
                          (((load_mode == LM_LH) || (load_mode == LM_LHU)) && address[0]));
    assign w_store_bad = mem_write && (address[1:0] != 2'b00);
    assign mem_misaligned = w_load_bad || w_store_bad;
`else
    assign w_load_bad  = 1'b0;
    assign w_store_bad = 1'b0;
`endif

    assign w_store_en = mem_write && !w_store_bad;

    always_comb begin
        w_load = '0;
        if (mem_read && !w_load_bad) begin
            case (load_mode)
                LM_LW:   w_load = w_word;
                LM_LH:   w_load = {{16{w_half[15]}}, w_half};
                LM_LHU:  w_load = {16'h0000, w_half};
                LM_LB:   w_load = {{24{w_byte[7]}}, w_byte};
                default: w_load = '0;
            endcase
        end
    end

    assign read_memory_out = w_load;

    // The RAM ignores reset: a store on an edge while rst_n is low still lands.
    always_ff @(posedge clk) begin
        if (w_store_en) begin
            r_mem[w_idx] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_back_destination_out <= '0;
            reg_write_out              <= 1'b0;
            mem_to_reg_out             <= 1'b0;
            read_data                  <= '0;
            address_out                <= '0;
        end else begin
            write_back_destination_out <= write_back_destination;
            reg_write_out              <= reg_write;
            mem_to_reg_out             <= mem_to_reg;
            read_data                  <= w_load;
            address_out                <= address;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_datapath.sv
// ============================================================================
// tb_mem_wb_datapath : directed + random checks against a byte-array model
// ============================================================================
`default_nettype none

module tb_mem_wb_datapath;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  load_mode = 2'b00;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [4:0]  write_back_destination = '0;
    logic [31:0] read_memory_out;
    logic [4:0]  write_back_destination_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic [31:0] read_data;
    logic [31:0] address_out;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        mem_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [MB];

    always #5 clk = ~clk;

    mem_wb_datapath #(.MEM_BYTES(MB)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .mem_read                   (mem_read),
        .mem_write                  (mem_write),
        .load_mode                  (load_mode),
        .address                    (address),
        .write_data                 (write_data),
        .reg_write                  (reg_write),
        .mem_to_reg                 (mem_to_reg),
        .write_back_destination     (write_back_destination),
`ifdef MEM_MISALIGN_CHECK_EN
        .mem_misaligned             (mem_misaligned),
`endif
        .read_memory_out            (read_memory_out),
        .write_back_destination_out (write_back_destination_out),
        .reg_write_out              (reg_write_out),
        .mem_to_reg_out             (mem_to_reg_out),
        .read_data                  (read_data),
        .address_out                (address_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic mdl_load_bad(input logic rd, input logic [1:0] mode, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
        if (!rd) return 1'b0;
        if (mode == 2'b00) return (a % 4) != 0;
        if (mode == 2'b01 || mode == 2'b10) return (a % 2) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic mdl_store_bad(input logic wr, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
        return wr && ((a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Loads computed byte-by-byte from the model array, big-endian.
    function automatic logic [31:0] mdl_load(input logic rd, input logic [1:0] mode, input logic [31:0] a);
        int off;
        int wb;
        int hb;
        logic [15:0] h;
        logic [7:0]  b;
        off = int'(a % MB);
        wb  = off - (off % 4);
        hb  = off - (off % 2);
        if (!rd || mdl_load_bad(rd, mode, a)) return 32'h0;
        h = {mdl[hb], mdl[hb+1]};
        b = mdl[off];
        case (mode)
            2'b00:   return {mdl[wb], mdl[wb+1], mdl[wb+2], mdl[wb+3]};
            2'b01:   return {{16{h[15]}}, h};
            2'b10:   return {16'h0, h};
            default: return {{24{b[7]}}, b};
        endcase
    endfunction

    task automatic step(input logic rd, input logic wr, input logic [1:0] mode,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic rw, input logic m2r, input logic [4:0] dst);
        logic [31:0] exp_comb;
        int wb;
        @(negedge clk);
        mem_read = rd; mem_write = wr; load_mode = mode; address = a;
        write_data = wd; reg_write = rw; mem_to_reg = m2r; write_back_destination = dst;
        #1;
        exp_comb = mdl_load(rd, mode, a);
        check("read_memory_out", read_memory_out, exp_comb);
`ifdef MEM_MISALIGN_CHECK_EN
        check("mem_misaligned", {31'b0, mem_misaligned},
              {31'b0, mdl_load_bad(rd, mode, a) || mdl_store_bad(wr, a)});
`endif
        @(posedge clk);
        if (wr && !mdl_store_bad(wr, a)) begin
            wb = int'(a % MB);
            wb = wb - (wb % 4);
            for (int k = 0; k < 4; k++) mdl[wb+k] = wd[31-8*k -: 8];
        end
        #1;
        if (rst_n) begin
            check("read_data", read_data, exp_comb);
            check("address_out", address_out, a);
            check("dest_out", {27'b0, write_back_destination_out}, {27'b0, dst});
            check("reg_write_out", {31'b0, reg_write_out}, {31'b0, rw});
            check("mem_to_reg_out", {31'b0, mem_to_reg_out}, {31'b0, m2r});
        end else begin
            check("rst_read_data", read_data, 32'h0);
            check("rst_address_out", address_out, 32'h0);
            check("rst_dest_out", {27'b0, write_back_destination_out}, 32'h0);
            check("rst_ctrl_out", {30'b0, reg_write_out, mem_to_reg_out}, 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < MB; i++) mdl[i] = 8'h00;
        #2;
        check("por_read_data", read_data, 32'h0);
        check("por_address_out", address_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word so the model never depends on power-up contents.
        for (int i = 0; i < MB / 4; i++)
            step(1'b0, 1'b1, 2'b00, 32'(i * 4), $urandom, 1'b0, 1'b0, 5'd0);

        // Asynchronous reset mid-cycle, plus a store that still lands during reset.
        step(1'b1, 1'b0, 2'b00, 32'h0000_0104, 32'h0, 1'b1, 1'b1, 5'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_read_data", read_data, 32'h0);
        check("async_rst_address_out", address_out, 32'h0);
        check("async_rst_ctrl", {25'b0, write_back_destination_out, reg_write_out, mem_to_reg_out}, 32'h0);
        step(1'b0, 1'b1, 2'b00, 32'h0000_0050, 32'h5A5A_A5A5, 1'b1, 1'b1, 5'd3);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 2'b00, 32'h0000_0050, 32'h0, 1'b1, 1'b0, 5'd4);
        check("store_in_reset", read_data, 32'h5A5A_A5A5);

        // Word round trip.
        step(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 1'b1, 5'd2);
        check("lw_10", read_data, 32'hDEAD_BEEF);
        check("lw_10_addr", address_out, 32'h10);

        // Sub-word loads.
        step(1'b0, 1'b1, 2'b00, 32'h20, 32'h8091_A2B3, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 2'b01, 32'h20, 32'h0, 1'b1, 1'b1, 5'd1);
        check("lh_20", read_data, 32'hFFFF_8091);
        step(1'b1, 1'b0, 2'b10, 32'h22, 32'h0, 1'b1, 1'b1, 5'd1);
        check("lhu_22", read_data, 32'h0000_A2B3);
        step(1'b1, 1'b0, 2'b11, 32'h21, 32'h0, 1'b1, 1'b1, 5'd1);
        check("lb_21", read_data, 32'hFFFF_FF91);
        step(1'b1, 1'b0, 2'b11, 32'h23, 32'h0, 1'b1, 1'b1, 5'd1);
        check("lb_23", read_data, 32'hFFFF_FFB3);

        // Read during write returns old data; new data next cycle.
        step(1'b0, 1'b1, 2'b00, 32'h30, 32'h1111_1111, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 2'b00, 32'h30, 32'h2222_2222, 1'b0, 1'b0, 5'd0);
        check("rdw_old", read_data, 32'h1111_1111);
        step(1'b1, 1'b0, 2'b00, 32'h30, 32'h0, 1'b0, 1'b0, 5'd0);
        check("rdw_new", read_data, 32'h2222_2222);

        // Address wrap and control pass-through.
        step(1'b0, 1'b1, 2'b00, 32'h400, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("wrap_lw_0", read_data, 32'hCAFE_F00D);
        step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 5'd17);
        check("noread_zero", read_data, 32'h0);
        check("dest_17", {27'b0, write_back_destination_out}, 32'd17);

`ifdef MEM_MISALIGN_CHECK_EN
        step(1'b0, 1'b1, 2'b00, 32'h40, 32'h1234_5678, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 2'b00, 32'h41, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, 1'b0, 5'd0);
        check("misalign_store_blocked", read_data, 32'h1234_5678);
        step(1'b1, 1'b0, 2'b10, 32'h43, 32'h0, 1'b0, 1'b0, 5'd0);
        check("misalign_lhu_zero", read_data, 32'h0);
`endif

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 2'($urandom), $urandom, $urandom,
                 1'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
